// File: rtl/lo_tune_if.sv
// Host-side retune and scan-control bundle for the LO tuning sequencer.
interface lo_tune_if #(
  parameter int PHASE_W = 32,
  parameter int DWELL_W = 24
);
  logic               tune_valid;
  logic               tune_ready;
  logic [PHASE_W-1:0] tune_word;
  logic               scan_start;
  logic [PHASE_W-1:0] scan_step;
  logic [PHASE_W-1:0] scan_stop_word;
  logic [DWELL_W-1:0] scan_dwell;
  logic               scan_abort;

  modport master (
    output tune_valid, tune_word, scan_start, scan_step, scan_stop_word,
           scan_dwell, scan_abort,
    input  tune_ready
  );

  modport slave (
    input  tune_valid, tune_word, scan_start, scan_step, scan_stop_word,
           scan_dwell, scan_abort,
    output tune_ready
  );
endinterface

// File: rtl/lo_tune_ctrl.sv
// Square-wave quadrature LO with glitch-free retune and an autonomous frequency scan.
// Word changes land only on an accumulator wrap (or at once when the current word is zero).
module lo_tune_ctrl #(
  parameter int          PHASE_W    = 32,
  parameter int          DWELL_W    = 24,
  parameter logic [31:0] RESET_WORD = 32'h0100_0000
) (
  input  logic               clk,
  input  logic               reset,
  lo_tune_if.slave           bus,
  output logic               sin_out,
  output logic               cos_out,
  output logic [PHASE_W-1:0] cur_word,
  output logic               busy,
  output logic               wrap,
  output logic               scan_done
);

  localparam logic [PHASE_W-1:0] INIT_WORD = PHASE_W'(RESET_WORD);

  typedef enum logic [1:0] {IDLE, TUNE_WAIT, SCAN_DWELL, SCAN_WAIT} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   sum;
  logic [PHASE_W:0]   nxt;
  logic               carry;
  logic               apply_ok;
  logic               scan_end;
  logic [PHASE_W-1:0] pending;
  logic [PHASE_W-1:0] step_q;
  logic [PHASE_W-1:0] stop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_eff;
  logic               dwell_last;

  assign sum        = {1'b0, acc} + {1'b0, cur_word};
  assign carry      = sum[PHASE_W];
  assign apply_ok   = carry || (cur_word == '0);
  assign nxt        = {1'b0, cur_word} + {1'b0, step_q};
  assign scan_end   = nxt[PHASE_W] || (nxt[PHASE_W-1:0] > stop_q);
  assign dwell_eff  = (bus.scan_dwell == '0) ? DWELL_W'(1) : bus.scan_dwell;
  assign dwell_last = (dwell_cnt == DWELL_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no branch of the case can infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.tune_valid)      state_nxt = TUNE_WAIT;
        else if (bus.scan_start) state_nxt = SCAN_DWELL;
      end
      TUNE_WAIT: begin
        if (apply_ok) state_nxt = IDLE;
      end
      SCAN_DWELL: begin
        if (bus.scan_abort) state_nxt = IDLE;
        else if (dwell_last) state_nxt = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        if (bus.scan_abort) state_nxt = IDLE;
        else if (apply_ok)  state_nxt = scan_end ? IDLE : SCAN_DWELL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tune_ready = (state == IDLE);
    busy           = (state != IDLE);
  end

  // The accumulator free-runs through every retune so LO phase stays continuous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cur_word  <= INIT_WORD;
      sin_out   <= 1'b0;
      cos_out   <= 1'b0;
      wrap      <= 1'b0;
      scan_done <= 1'b0;
      pending   <= '0;
      step_q    <= '0;
      stop_q    <= '0;
      dwell_q   <= DWELL_W'(1);
      dwell_cnt <= DWELL_W'(1);
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      acc       <= sum[PHASE_W-1:0];
      sin_out   <= acc[PHASE_W-1];
      cos_out   <= acc[PHASE_W-1] ^ acc[PHASE_W-2];
      wrap      <= carry;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tune_valid) begin
            pending <= bus.tune_word;
          end else if (bus.scan_start) begin
            step_q    <= bus.scan_step;
            stop_q    <= bus.scan_stop_word;
            dwell_q   <= dwell_eff;
            dwell_cnt <= dwell_eff;
          end
        end
        TUNE_WAIT: begin
          if (apply_ok) cur_word <= pending;
        end
        SCAN_DWELL: begin
          if (!bus.scan_abort) dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
        SCAN_WAIT: begin
          if (!bus.scan_abort && apply_ok) begin
            if (scan_end) begin
              scan_done <= 1'b1;
            end else begin
              cur_word  <= nxt[PHASE_W-1:0];
              dwell_cnt <= dwell_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lo_tune_ctrl.sv
// Self-checking bench for lo_tune_ctrl: directed test-plan steps plus random traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_lo_tune_ctrl;
  localparam int PW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          sin_out, cos_out, busy, wrap, scan_done;
  logic [PW-1:0] cur_word;

  lo_tune_if #(.PHASE_W(PW), .DWELL_W(DW)) bus ();

  lo_tune_ctrl #(.PHASE_W(PW), .DWELL_W(DW), .RESET_WORD(32'h40)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .cur_word  (cur_word),
    .busy      (busy),
    .wrap      (wrap),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  // Reference model: plain integer arithmetic, phase in 0..255, quadrant = acc/64.
  typedef enum {M_IDLE, M_TUNE, M_DWELL, M_WAIT} mode_t;
  mode_t m_mode;
  int    m_acc, m_word, m_pend, m_step, m_stop, m_dwell, m_left;
  bit    m_sin, m_cos, m_wrap, m_done;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_acc = 0; m_word = 'h40; m_pend = 0;
    m_step = 0; m_stop = 0; m_dwell = 1; m_left = 1;
    m_sin = 0; m_cos = 0; m_wrap = 0; m_done = 0;
  endtask

  task automatic model_update();
    int sum, quad;
    bit apply;
    sum   = m_acc + m_word;
    apply = (sum >= 256) || (m_word == 0);
    quad  = m_acc / 64;
    m_sin  = (quad >= 2);
    m_cos  = (quad == 1) || (quad == 2);
    m_wrap = (sum >= 256);
    m_done = 0;
    case (m_mode)
      M_IDLE: begin
        if (bus.tune_valid) begin
          m_pend = int'(bus.tune_word); m_mode = M_TUNE;
        end else if (bus.scan_start) begin
          m_step  = int'(bus.scan_step);
          m_stop  = int'(bus.scan_stop_word);
          m_dwell = (bus.scan_dwell == 0) ? 1 : int'(bus.scan_dwell);
          m_left  = m_dwell;
          m_mode  = M_DWELL;
        end
      end
      M_TUNE: if (apply) begin m_word = m_pend; m_mode = M_IDLE; end
      M_DWELL: begin
        if (bus.scan_abort) m_mode = M_IDLE;
        else begin m_left--; if (m_left == 0) m_mode = M_WAIT; end
      end
      M_WAIT: begin
        if (bus.scan_abort) m_mode = M_IDLE;
        else if (apply) begin
          if (m_word + m_step > m_stop) begin m_done = 1; m_mode = M_IDLE; end
          else begin m_word = m_word + m_step; m_left = m_dwell; m_mode = M_DWELL; end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_acc = sum % 256;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check("sin_out",    32'(sin_out),        32'(m_sin));
    check("cos_out",    32'(cos_out),        32'(m_cos));
    check("wrap",       32'(wrap),           32'(m_wrap));
    check("scan_done",  32'(scan_done),      32'(m_done));
    check("cur_word",   32'(cur_word),       32'(m_word));
    check("busy",       32'(busy),           32'(m_mode != M_IDLE));
    check("tune_ready", 32'(bus.tune_ready), 32'(m_mode == M_IDLE));
    if (scan_done === 1'b1) done_seen++;
  endtask

  task automatic do_tune(logic [PW-1:0] w);
    logic ok;
    int   n;
    n = 0;
    bus.tune_valid = 1'b1;
    bus.tune_word  = w;
    do begin ok = bus.tune_ready; tick(); n++; end while (ok !== 1'b1 && n < 300);
    bus.tune_valid = 1'b0;
    check("tune_accept", 32'(ok), 32'd1);
  endtask

  task automatic start_scan(logic [PW-1:0] step, logic [PW-1:0] stop, logic [DW-1:0] dwell);
    bus.scan_start = 1'b1; bus.scan_step = step; bus.scan_stop_word = stop; bus.scan_dwell = dwell;
    tick();
    bus.scan_start = 1'b0;
  endtask

  task automatic run_until_idle(string tag, int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    check({tag, "_idle_in_budget"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit            exp_sin[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};
    bit            exp_cos[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    bit            exp_wrap[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int            d0, busy_cycles, n, last_change;
    logic [PW-1:0] prev;
    logic [PW-1:0] changes[$];
    logic          ok;

    reset = 1'b1;
    bus.tune_valid = 0; bus.tune_word = 0; bus.scan_start = 0; bus.scan_step = 0;
    bus.scan_stop_word = 0; bus.scan_dwell = 0; bus.scan_abort = 0;
    model_reset();
    #12;
    check("rst_cur_word", 32'(cur_word), 32'h40);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.tune_ready), 32'd1);
    check("rst_sin_cos_wrap", {29'd0, sin_out, cos_out, wrap}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Free-run at word 0x40: four-cycle quadrant sequence.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("free_sin", 32'(sin_out), 32'(exp_sin[i]));
      check("free_cos", 32'(cos_out), 32'(exp_cos[i]));
      check("free_wrap", 32'(wrap), 32'(exp_wrap[i]));
    end

    // Glitch-free retune from mid-period; new word must appear together with wrap.
    tick();
    do_tune(8'h20);
    check("retune_ready_low", 32'(bus.tune_ready), 32'd0);
    check("retune_word_held", 32'(cur_word), 32'h40);
    n = 0;
    while (cur_word !== 8'h20 && n < 20) begin tick(); n++; end
    check("retune_applied", 32'(cur_word), 32'h20);
    check("retune_at_wrap", 32'(wrap), 32'd1);
    run_until_idle("retune", 10);

    // Zero-word retune: applied on the cycle after accept.
    do_tune(8'h00);
    run_until_idle("to_zero", 300);
    do_tune(8'h10);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 10) begin busy_cycles++; tick(); end
    check("zero_busy_cycles", busy_cycles, 32'd1);
    check("zero_applied", 32'(cur_word), 32'h10);

    // Scan 10 -> 20 -> 30 with dwell 3, then scan_done once.
    d0 = done_seen;
    start_scan(8'h10, 8'h30, 8'd3);
    prev = cur_word; last_change = 0; n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick(); n++;
      if (cur_word !== prev) begin
        changes.push_back(cur_word);
        check("scan_change_at_wrap", 32'(wrap), 32'd1);
        check("scan_change_gap_ok", 32'(n - last_change >= 3), 32'd1);
        last_change = n; prev = cur_word;
      end
    end
    check("scan_idle", 32'(busy), 32'd0);
    check("scan_num_changes", changes.size(), 32'd2);
    if (changes.size() == 2) begin
      check("scan_word_1", 32'(changes[0]), 32'h20);
      check("scan_word_2", 32'(changes[1]), 32'h30);
    end
    check("scan_done_count", done_seen - d0, 32'd1);
    check("scan_final_word", 32'(cur_word), 32'h30);

    // Overflow termination: F0 + 20 carries out, so no change.
    do_tune(8'hF0);
    run_until_idle("to_f0", 300);
    d0 = done_seen;
    start_scan(8'h20, 8'hFF, 8'd2);
    n = 0; ok = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      tick(); n++;
      if (scan_done === 1'b1) ok = wrap;
    end
    check("ovf_idle", 32'(busy), 32'd0);
    check("ovf_done_count", done_seen - d0, 32'd1);
    check("ovf_done_with_wrap", 32'(ok), 32'd1);
    check("ovf_word_kept", 32'(cur_word), 32'hF0);

    // Abort during dwell.
    do_tune(8'h20);
    run_until_idle("to_20", 300);
    d0 = done_seen;
    start_scan(8'h10, 8'hF0, 8'd5);
    tick(); tick();
    bus.scan_abort = 1'b1;
    tick();
    bus.scan_abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_word_kept", 32'(cur_word), 32'h20);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_done", done_seen - d0, 32'd0);

    // tune_valid and scan_start together: tune only.
    d0 = done_seen;
    bus.tune_valid = 1'b1; bus.tune_word = 8'h30;
    bus.scan_start = 1'b1; bus.scan_step = 8'h10; bus.scan_stop_word = 8'hFF; bus.scan_dwell = 8'd1;
    tick();
    bus.tune_valid = 1'b0; bus.scan_start = 1'b0;
    run_until_idle("prio", 300);
    for (int i = 0; i < 16; i++) tick();
    check("prio_word", 32'(cur_word), 32'h30);
    check("prio_still_idle", 32'(busy), 32'd0);
    check("prio_no_done", done_seen - d0, 32'd0);

    // Asynchronous reset mid-scan.
    start_scan(8'h10, 8'hFF, 8'd4);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("arst_cur_word", 32'(cur_word), 32'h40);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(bus.tune_ready), 32'd1);
    check("arst_outs", {28'd0, sin_out, cos_out, wrap, scan_done}, 32'd0);
    model_reset();
    @(negedge clk) reset = 1'b0;

    // Random traffic against the model; requester holds valid/word until accepted.
    for (int i = 0; i < 600; i++) begin
      if (bus.tune_valid !== 1'b1 && $urandom_range(0, 11) == 0) begin
        bus.tune_valid = 1'b1;
        bus.tune_word  = PW'($urandom_range(0, 255));
      end
      bus.scan_start = ($urandom_range(0, 14) == 0);
      if (bus.scan_start) begin
        bus.scan_step      = PW'($urandom_range(0, 48));
        bus.scan_stop_word = PW'($urandom_range(0, 255));
        bus.scan_dwell     = DW'($urandom_range(0, 4));
      end
      bus.scan_abort = ($urandom_range(0, 39) == 0);
      ok = bus.tune_ready;
      tick();
      if (bus.tune_valid === 1'b1 && ok === 1'b1) bus.tune_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lo_tune_ctrl.md
Name: lo_tune_ctrl

Overview:
Local-oscillator generator and tuning sequencer for the 1-bit quadrature mixer. A phase accumulator produces square-wave sin/cos LO bits that drive the mixer's sin_in/cos_in inputs. The block accepts host retune requests over a valid/ready handshake and applies each new frequency word only at an accumulator wrap, so the LO has no glitches. It also runs an autonomous frequency scan (start, step, stop, dwell) for band sweeps.

Parameters:
PHASE_W, 32, accumulator and frequency-word width (min 4)
DWELL_W, 24, dwell counter width
RESET_WORD, 32'h0100_0000, phase increment after reset (truncated to PHASE_W)

Ports:
clk  in  1  system clock, same domain as the mixer
reset  in  1  asynchronous, active-high reset
tune_valid  in  1  retune request valid
tune_ready  out  1  retune request accepted when valid&&ready
tune_word  in  PHASE_W  requested phase increment
scan_start  in  1  single-cycle pulse; starts a scan from the current word
scan_step  in  PHASE_W  increment added per scan step; sampled at start
scan_stop_word  in  PHASE_W  last permitted word; sampled at start
scan_dwell  in  DWELL_W  cycles per scan point; sampled at start
scan_abort  in  1  terminates a scan
sin_out  out  1  LO in-phase bit, to mixer sin_in
cos_out  out  1  LO quadrature bit, to mixer cos_in
cur_word  out  PHASE_W  phase increment currently in use
busy  out  1  high in any state other than IDLE
wrap  out  1  one-cycle pulse, registered accumulator carry-out
scan_done  out  1  one-cycle pulse when a scan completes normally

Behaviour:
- Reset (async, any state): acc=0, cur_word=RESET_WORD, state=IDLE, sin_out=0, cos_out=0, wrap=0, scan_done=0, busy=0, tune_ready=1. Everything in flight is discarded.
- Accumulator: every cycle acc <= (acc + cur_word) mod 2^PHASE_W. carry = carry-out of that add.
- Registered outputs, updated one cycle after acc:
  - sin_out = acc[MSB]
  - cos_out = acc[MSB] ^ acc[MSB-1]
  - Quadrant sequence 0,1,2,3 gives sin 0,0,1,1 and cos 0,1,1,0.
  - wrap is the registered carry.
- apply_ok = carry || (cur_word==0). A zero word never wraps, so it is replaced immediately.
- States: IDLE, TUNE_WAIT, SCAN_DWELL, SCAN_WAIT.
- IDLE:
  - tune_ready=1.
  - tune_valid: latch tune_word into pending, then go to TUNE_WAIT.
  - Else scan_start: latch step, stop and dwell (dwell=0 is treated as 1), load the dwell counter, then go to SCAN_DWELL.
  - tune_valid and scan_start in the same cycle: tune wins and scan_start is dropped.
- TUNE_WAIT:
  - tune_ready=0.
  - On the first cycle with apply_ok: cur_word <= pending, effective for the next add. Return to IDLE.
  - Worst-case latency is one LO period.
- SCAN_DWELL:
  - tune_ready=0.
  - The counter decrements each cycle. After dwell cycles, go to SCAN_WAIT.
- SCAN_WAIT:
  - nxt = cur_word + step, computed PHASE_W+1 bits wide.
  - On apply_ok:
    - If nxt[PHASE_W]==1 or nxt[PHASE_W-1:0] > stop (unsigned): cur_word is unchanged, scan_done pulses, go to IDLE.
    - Else: cur_word <= nxt, reload the dwell counter, go to SCAN_DWELL.
  - step=0 never terminates; only abort ends it.
  - If the start word already exceeds stop, the scan ends at the first dwell boundary with no change.
- scan_abort:
  - In SCAN_DWELL or SCAN_WAIT: go to IDLE next cycle. cur_word keeps its value, no scan_done pulse.
  - Ignored in IDLE and TUNE_WAIT.
- tune_valid outside IDLE is held off by tune_ready=0. The requester must hold valid and word until accepted.
- The accumulator never stops or resets on retune. Phase is continuous across every word change.

Test Plan:
- Reset and free-run: PHASE_W=8, RESET_WORD=8'h40 -> acc 00,40,80,C0,00; sin 0,0,1,1 repeating; cos 0,1,1,0 repeating; wrap pulse every 4 cycles; busy=0; tune_ready=1.
- Glitch-free retune: PHASE_W=8, word 40; accept tune_word=20 mid-period -> tune_ready low; cur_word stays 40 until the wrap cycle, then 20; sin period goes from 4 to 8 cycles with no short pulse.
- Zero-word retune: cur_word=00, tune_word=10 -> applied in the cycle after accept; busy high for exactly 1 cycle.
- Scan: word 10, step 10, stop 30, dwell 3 -> cur_word sequence 10, 20, 30, each change at a wrap ≥3 cycles after the previous; then scan_done once, cur_word=30, IDLE.
- Overflow termination: PHASE_W=8, word F0, step 20, stop FF -> no change; scan_done at the first dwell boundary that coincides with a wrap.
- Abort, priority and reset: scan_abort in SCAN_DWELL -> IDLE next cycle, no scan_done. tune_valid with scan_start in the same cycle -> tune only. Async reset asserted mid-scan -> all outputs at reset values immediately, cur_word=RESET_WORD.
